// File: rtl/dly_capture_fifo.sv
// Capture FIFO behind a selectable-tap delay line: hold off input until the chosen tap is
// valid, buffer accepted bytes in a FWFT FIFO, flag overflow. Option: DLY_CAPTURE_STATS_EN.
module dly_capture_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 din,
  input  logic [1:0]                 sel,
  input  logic                       in_vld,
  output logic [7:0]                 out_data,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       warm,
  output logic                       ovf,
  input  logic                       ovf_clr
`ifdef DLY_CAPTURE_STATS_EN
  ,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = DEPTH[AW:0];

  typedef enum logic [0:0] {StWarm, StStream} state_e;

  state_e         state_q;
  logic [1:0]     wcnt_q;
  logic [1:0]     sel_q;
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    count_q;
  logic           ovf_q;
  logic [7:0]     mem [DEPTH];

  logic full;
  logic empty;
  logic stream_ok;
  logic push;
  logic pop;
  logic full_drop;

  assign full      = (count_q == FullCnt);
  assign empty     = (count_q == '0);
  assign stream_ok = (state_q == StStream) && (sel == sel_q);
  assign pop       = !empty && out_rdy;
  assign push      = stream_ok && in_vld && (!full || pop);
  assign full_drop = stream_ok && in_vld && full && !pop;

  assign out_vld  = !empty;
  assign out_data = mem[rd_ptr_q];
  assign count    = count_q;
  assign warm     = (state_q == StWarm);
  assign ovf      = ovf_q;

  // Warm-up tracks how many cycles the currently selected tap has been stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWarm;
      wcnt_q  <= 2'd0;
      sel_q   <= sel;
    end else begin
      unique case (state_q)
        StWarm: begin
          if (sel != sel_q) begin
            sel_q  <= sel;
            wcnt_q <= 2'd0;
          end else if (wcnt_q == sel_q) begin
            state_q <= StStream;
          end else begin
            wcnt_q <= wcnt_q + 2'd1;
          end
        end
        StStream: begin
          if (sel != sel_q) begin
            sel_q   <= sel;
            wcnt_q  <= 2'd0;
            state_q <= StWarm;
          end
        end
        default: state_q <= StWarm;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      // A new drop takes priority over a clear in the same cycle.
      if (full_drop)    ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

`ifdef DLY_CAPTURE_STATS_EN
  logic drop;
  assign drop = in_vld && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 16'd0;
    end else if (drop) begin
      if (ovf_clr)                  drop_cnt <= 16'd1;
      else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end else if (ovf_clr) begin
      drop_cnt <= 16'd0;
    end
  end
`endif

endmodule

// File: tb/tb_dly_capture_fifo.sv
// Directed self-checking bench for dly_capture_fifo (DEPTH=8).
module tb_dly_capture_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic [1:0] sel;
  logic       in_vld;
  logic [7:0] out_data;
  logic       out_vld;
  logic       out_rdy;
  logic [3:0] count;
  logic       warm;
  logic       ovf;
  logic       ovf_clr;
`ifdef DLY_CAPTURE_STATS_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int failures = 0;

  dly_capture_fifo #(.DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .sel      (sel),
    .in_vld   (in_vld),
    .out_data (out_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .count    (count),
    .warm     (warm),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
`ifdef DLY_CAPTURE_STATS_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic exp_warm;
    rst_n = 1'b0; sel = 2'd3; in_vld = 1'b1; din = 8'h01; out_rdy = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", out_vld); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      din = 8'(k);
      exp_warm = (k <= 4);
      checks++;
      if (warm !== exp_warm) begin
        failures++; $display("FAIL warm_cycle%0d got=%b exp=%b", k, warm, exp_warm);
      end
      tick();
    end
    in_vld = 1'b0;
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL warm_count got=%0d exp=2", count); end
    checks++; if (out_data !== 8'h05) begin failures++; $display("FAIL first_byte got=%h exp=05", out_data); end
`ifdef DLY_CAPTURE_STATS_EN
    checks++; if (drop_cnt !== 16'd4) begin failures++; $display("FAIL warm_drops got=%0d exp=4", drop_cnt); end
`endif
  endtask

  task automatic test_fill_overflow();
    out_rdy = 1'b1;
    checks++; if (out_data !== 8'h05) begin failures++; $display("FAIL pre_drain0 got=%h exp=05", out_data); end
    tick();
    checks++; if (out_data !== 8'h06) begin failures++; $display("FAIL pre_drain1 got=%h exp=06", out_data); end
    tick();
    out_rdy = 1'b0;
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL pre_drain_vld got=%b exp=0", out_vld); end
    sel = 2'd0;
    tick(); tick();
    checks++; if (warm !== 1'b0) begin failures++; $display("FAIL sel0_warm got=%b exp=0", warm); end
    for (int i = 0; i < 8; i++) begin
      in_vld = 1'b1; din = 8'h11 + 8'(i);
      tick();
    end
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL fill_count got=%0d exp=8", count); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL fill_ovf got=%b exp=0", ovf); end
    din = 8'h19;
    tick();
    in_vld = 1'b0;
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf); end
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
    checks++; if (out_data !== 8'h11) begin failures++; $display("FAIL ovf_head got=%h exp=11", out_data); end
  endtask

  task automatic test_drain();
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_vld !== 1'b1 || out_data !== 8'h11 + 8'(i)) begin
        failures++;
        $display("FAIL drain%0d got=%h/%b exp=%h/1", i, out_data, out_vld, 8'h11 + 8'(i));
      end
      tick();
    end
    out_rdy = 1'b0;
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL drain_vld got=%b exp=0", out_vld); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", count); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", ovf); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) begin
      in_vld = 1'b1; din = 8'h21 + 8'(i);
      tick();
    end
    din = 8'h29; out_rdy = 1'b1;
    tick();
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL pp_count got=%0d exp=8", count); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL pp_ovf got=%b exp=0", ovf); end
    checks++; if (out_data !== 8'h22) begin failures++; $display("FAIL pp_head got=%h exp=22", out_data); end
    din = 8'h2A; out_rdy = 1'b0; ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0; in_vld = 1'b0;
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL set_wins got=%b exp=1", ovf); end
`ifdef DLY_CAPTURE_STATS_EN
    checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL drop_clr got=%0d exp=1", drop_cnt); end
`endif
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_data !== 8'h22 + 8'(i)) begin
        failures++; $display("FAIL pp_drain%0d got=%h exp=%h", i, out_data, 8'h22 + 8'(i));
      end
      tick();
    end
    out_rdy = 1'b0;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL pp_empty got=%0d exp=0", count); end
  endtask

  task automatic test_tap_change();
    sel = 2'd1;
    repeat (4) tick();
    checks++; if (warm !== 1'b0) begin failures++; $display("FAIL sel1_warm got=%b exp=0", warm); end
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1; din = 8'h31 + 8'(i);
      tick();
    end
    sel = 2'd2; din = 8'h40; out_rdy = 1'b1;
    checks++; if (warm !== 1'b0) begin failures++; $display("FAIL tc_warmA got=%b exp=0", warm); end
    checks++; if (out_data !== 8'h31) begin failures++; $display("FAIL tc_head0 got=%h exp=31", out_data); end
    tick();
    din = 8'h41;
    checks++; if (warm !== 1'b1) begin failures++; $display("FAIL tc_warmB got=%b exp=1", warm); end
    checks++; if (out_data !== 8'h32) begin failures++; $display("FAIL tc_head1 got=%h exp=32", out_data); end
    tick();
    din = 8'h42;
    checks++; if (warm !== 1'b1) begin failures++; $display("FAIL tc_warmC got=%b exp=1", warm); end
    checks++; if (out_data !== 8'h33) begin failures++; $display("FAIL tc_head2 got=%h exp=33", out_data); end
    tick();
    din = 8'h43; out_rdy = 1'b0;
    checks++; if (warm !== 1'b1) begin failures++; $display("FAIL tc_warmD got=%b exp=1", warm); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL tc_count got=%0d exp=0", count); end
    tick();
    din = 8'h44;
    checks++; if (warm !== 1'b0) begin failures++; $display("FAIL tc_warmE got=%b exp=0", warm); end
    tick();
    in_vld = 1'b0;
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL tc_after got=%0d exp=1", count); end
    checks++; if (out_data !== 8'h44) begin failures++; $display("FAIL tc_byte got=%h exp=44", out_data); end
`ifdef DLY_CAPTURE_STATS_EN
    checks++; if (drop_cnt !== 16'd4) begin failures++; $display("FAIL tc_drops got=%0d exp=4", drop_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    logic exp_warm;
    for (int i = 0; i < 8; i++) begin
      in_vld = 1'b1; din = 8'h51 + 8'(i);
      tick();
    end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL rm_ovf got=%b exp=1", ovf); end
    din = 8'h60; out_rdy = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL rm_vld got=%b exp=0", out_vld); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL rm_count got=%0d exp=0", count); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rm_ovf_clr got=%b exp=0", ovf); end
    checks++; if (warm !== 1'b1) begin failures++; $display("FAIL rm_warm got=%b exp=1", warm); end
`ifdef DLY_CAPTURE_STATS_EN
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL rm_drops got=%0d exp=0", drop_cnt); end
`endif
    tick();
    rst_n = 1'b1; out_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      din = 8'h70 + 8'(k);
      exp_warm = (k < 3);
      checks++;
      if (warm !== exp_warm) begin
        failures++; $display("FAIL rm_warm%0d got=%b exp=%b", k, warm, exp_warm);
      end
      tick();
    end
    in_vld = 1'b0;
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL rm_after got=%0d exp=1", count); end
    checks++; if (out_data !== 8'h73) begin failures++; $display("FAIL rm_byte got=%h exp=73", out_data); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain();
    test_full_push_pop();
    test_tap_change();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
